// File: rtl/lzd_norm_arbiter.sv
// rtl/lzd_norm_arbiter.sv - two-requester round-robin front end for a shared 2-stage LZD + left-normalize pipe
// Optional statistics counters: define LZD_NORM_ARB_STATS_EN.
module lzd_norm_arbiter #(
    parameter int M                   = 23,
    parameter int extra_bits_mantissa = 7,
    parameter int sign_mantissa_bit   = 1,
    parameter int W                   = M + extra_bits_mantissa - sign_mantissa_bit,
    parameter int SHIFT_WIDTH         = $clog2(W - 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [W-1:0]           req0_mant,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [W-1:0]           req1_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_mant,
    output logic [SHIFT_WIDTH:0]   out_shift,
    output logic                   out_zero,
`ifdef LZD_NORM_ARB_STATS_EN
    output logic [15:0]            grant_cnt0,
    output logic [15:0]            grant_cnt1,
    output logic [15:0]            stall_cnt,
`endif
    output logic                   out_id
);

    localparam int CW = SHIFT_WIDTH + 1;

    logic           s1_valid;
    logic [W-1:0]   s1_mant;
    logic           s1_id;
    logic           rr_ptr;

    logic           s2_accept;
    logic           s1_accept;
    logic           grant0;
    logic           grant1;
    logic           xfer;
    logic [W-1:0]   in_mant;

    logic [CW-1:0]  lzd_cnt;
    logic           lzd_zero;
    logic [W-1:0]   lzd_mant;

    assign s2_accept = !out_valid | out_ready;
    assign s1_accept = !s1_valid | s2_accept;

    // rr_ptr only breaks ties; a lone requester always wins
    assign grant0 = req0_valid & (!req1_valid | !rr_ptr);
    assign grant1 = req1_valid & (!req0_valid |  rr_ptr);

    assign req0_ready = grant0 & s1_accept;
    assign req1_ready = grant1 & s1_accept;
    assign xfer       = req0_ready | req1_ready;
    assign in_mant    = grant1 ? req1_mant : req0_mant;

    // Scan from LSB upward so the last hit is the most-significant one
    always_comb begin
        lzd_cnt  = CW'(1 << SHIFT_WIDTH);
        lzd_zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (s1_mant[i]) begin
                lzd_cnt  = CW'(W - 1 - i);
                lzd_zero = 1'b0;
            end
        end
        lzd_mant = lzd_zero ? '0 : (s1_mant << lzd_cnt[SHIFT_WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_id    <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            if (s1_accept) begin
                s1_valid <= xfer;
            end
            if (xfer) begin
                s1_mant <= in_mant;
                s1_id   <= grant1;
                rr_ptr  <= ~grant1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
            out_id    <= 1'b0;
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant  <= lzd_mant;
                out_shift <= lzd_cnt;
                out_zero  <= lzd_zero;
                out_id    <= s1_id;
            end
        end
    end

`ifdef LZD_NORM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (req1_ready && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
